// File: rtl/ps2_dev_tx_if.sv
// Transmit request/status bundle between a client and the PS/2 device transmitter.
interface ps2_dev_tx_if;
    logic       tx_en_i;
    logic [7:0] tx_data_i;
    logic       tx_busy_o;
    logic       tx_done_o;
    logic       tx_fail_o;

    // Client side: issues requests, observes status.
    modport master (
        output tx_en_i,
        output tx_data_i,
        input  tx_busy_o,
        input  tx_done_o,
        input  tx_fail_o
    );

    // Transmitter side: accepts requests, reports status.
    modport slave (
        input  tx_en_i,
        input  tx_data_i,
        output tx_busy_o,
        output tx_done_o,
        output tx_fail_o
    );
endinterface

// File: rtl/ps2_dev_tx.sv
// PS/2 device-to-host byte transmitter. Generates the CLK line itself, waits
// for an idle bus before starting, and aborts if the host inhibits CLK.
module ps2_dev_tx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int HALF_TICKS = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    ps2_dev_tx_if.slave  tx,
    input  logic         ps2_clk_i,
    input  logic         ps2_data_i,
    output logic         ps2_clk_oe_o,
    output logic         ps2_data_oe_o
);
    localparam int PRESCALE    = CLK_FREQ / 200000;
    localparam int PRE_W       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SETUP_TICKS = HALF_TICKS / 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_IDLE = 3'd1,
        ST_SETUP     = 3'd2,
        ST_CLK_LOW   = 3'd3,
        ST_CLK_HIGH  = 3'd4,
        ST_DONE      = 3'd5,
        ST_FAIL      = 3'd6
    } state_t;

    // Odd parity: parity bit makes the count of ones over data+parity odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~(^d);
    endfunction

    logic [1:0]       clk_sync_r;
    logic [1:0]       data_sync_r;
    logic             clk_s;
    logic             data_s;
    logic [PRE_W-1:0] pre_cnt_r;
    logic             tick_s;
    logic [3:0]       idle_cnt_r;
    logic             line_idle_s;

    state_t           state_r, state_nxt;
    logic [3:0]       idx_r, idx_nxt;
    logic [7:0]       tcnt_r, tcnt_nxt;
    logic [10:0]      frame_r, frame_nxt;

    logic             clk_oe_s, data_oe_s, busy_s, done_s, fail_s;
    logic             clk_oe_r, data_oe_r, busy_r, done_r, fail_r;

    assign clk_s       = clk_sync_r[1];
    assign data_s      = data_sync_r[1];
    assign tick_s      = (pre_cnt_r == PRE_W'(PRESCALE - 1));
    assign line_idle_s = (idle_cnt_r == 4'd10);

    // Two-stage synchronizers for the asynchronous bus lines (idle level is high).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_sync_r  <= 2'b11;
            data_sync_r <= 2'b11;
        end else begin
            clk_sync_r  <= {clk_sync_r[0], ps2_clk_i};
            data_sync_r <= {data_sync_r[0], ps2_data_i};
        end
    end

    // Free-running prescaler producing the 5 us tick.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pre_cnt_r <= '0;
        end else if (tick_s) begin
            pre_cnt_r <= '0;
        end else begin
            pre_cnt_r <= pre_cnt_r + PRE_W'(1);
        end
    end

    // Bus-idle detector: both lines high for 10 consecutive ticks.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idle_cnt_r <= 4'd0;
        end else if (!clk_s || !data_s) begin
            idle_cnt_r <= 4'd0;
        end else if (tick_s && !line_idle_s) begin
            idle_cnt_r <= idle_cnt_r + 4'd1;
        end else begin
            idle_cnt_r <= idle_cnt_r;
        end
    end

    // FSM state and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            idx_r   <= 4'd0;
            tcnt_r  <= 8'd0;
            frame_r <= 11'd0;
        end else begin
            state_r <= state_nxt;
            idx_r   <= idx_nxt;
            tcnt_r  <= tcnt_nxt;
            frame_r <= frame_nxt;
        end
    end

    // Next-state logic. Phase changes happen only on ticks so every phase
    // lasts a whole number of tick periods. Host inhibit is only honoured
    // once a tick has passed in the phase, giving the released CLK line time
    // to propagate through the synchronizer.
    always_comb begin
        state_nxt = state_r;
        idx_nxt   = idx_r;
        tcnt_nxt  = tcnt_r;
        frame_nxt = frame_r;
        case (state_r)
            ST_IDLE: begin
                if (tx.tx_en_i) begin
                    frame_nxt = {1'b1, odd_parity(tx.tx_data_i), tx.tx_data_i, 1'b0};
                    state_nxt = ST_WAIT_IDLE;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (line_idle_s && tick_s) begin
                    state_nxt = ST_SETUP;
                    idx_nxt   = 4'd0;
                    tcnt_nxt  = 8'd0;
                end else begin
                    state_nxt = ST_WAIT_IDLE;
                end
            end
            ST_SETUP: begin
                if (!clk_s && (tcnt_r != 8'd0)) begin
                    state_nxt = ST_FAIL;
                end else if (tick_s) begin
                    if (tcnt_r == 8'(SETUP_TICKS - 1)) begin
                        state_nxt = ST_CLK_LOW;
                        tcnt_nxt  = 8'd0;
                    end else begin
                        tcnt_nxt  = tcnt_r + 8'd1;
                    end
                end else begin
                    state_nxt = ST_SETUP;
                end
            end
            ST_CLK_LOW: begin
                if (tick_s) begin
                    if (tcnt_r == 8'(HALF_TICKS - 1)) begin
                        state_nxt = ST_CLK_HIGH;
                        tcnt_nxt  = 8'd0;
                    end else begin
                        tcnt_nxt  = tcnt_r + 8'd1;
                    end
                end else begin
                    state_nxt = ST_CLK_LOW;
                end
            end
            ST_CLK_HIGH: begin
                if (!clk_s && (tcnt_r != 8'd0)) begin
                    state_nxt = ST_FAIL;
                end else if (tick_s) begin
                    if (tcnt_r == 8'(SETUP_TICKS - 1)) begin
                        tcnt_nxt = 8'd0;
                        if (idx_r < 4'd10) begin
                            idx_nxt   = idx_r + 4'd1;
                            state_nxt = ST_SETUP;
                        end else begin
                            state_nxt = ST_DONE;
                        end
                    end else begin
                        tcnt_nxt = tcnt_r + 8'd1;
                    end
                end else begin
                    state_nxt = ST_CLK_HIGH;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            ST_FAIL: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so registered outputs line up with it.
    always_comb begin
        clk_oe_s  = 1'b0;
        data_oe_s = 1'b0;
        done_s    = 1'b0;
        fail_s    = 1'b0;
        busy_s    = (state_nxt != ST_IDLE);
        case (state_nxt)
            ST_SETUP:    data_oe_s = ~frame_nxt[idx_nxt];
            ST_CLK_HIGH: data_oe_s = ~frame_nxt[idx_nxt];
            ST_CLK_LOW: begin
                clk_oe_s  = 1'b1;
                data_oe_s = ~frame_nxt[idx_nxt];
            end
            ST_DONE:     done_s = 1'b1;
            ST_FAIL:     fail_s = 1'b1;
            default:     clk_oe_s = 1'b0;
        endcase
    end

    // Registered outputs; reset releases both lines and drops all status.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            fail_r    <= 1'b0;
        end else begin
            clk_oe_r  <= clk_oe_s;
            data_oe_r <= data_oe_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            fail_r    <= fail_s;
        end
    end

    assign ps2_clk_oe_o  = clk_oe_r;
    assign ps2_data_oe_o = data_oe_r;
    assign tx.tx_busy_o  = busy_r;
    assign tx.tx_done_o  = done_r;
    assign tx.tx_fail_o  = fail_r;
endmodule

// File: tb/tb_ps2_dev_tx.sv
// Bench for ps2_dev_tx: open-drain bus model with a host that can hold the
// lines low, a scoreboard of expected frame outcomes, and a monitor that
// decodes bits on each CLK low pulse and checks pulse widths.
module tb_ps2_dev_tx;
    localparam int CLK_FREQ   = 2000000;          // 10 cycles per 5 us tick
    localparam int HALF_TICKS = 8;
    localparam int TICK_CYC   = CLK_FREQ / 200000;
    localparam int HALF_CYC   = HALF_TICKS * TICK_CYC;

    typedef struct packed {
        logic        is_fail;
        logic [10:0] frame;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic host_clk_low  = 1'b0;
    logic host_data_low = 1'b0;
    logic ps2_clk, ps2_data, clk_oe, data_oe;

    int   errors = 0;
    int   checks = 0;
    int   pulse_cnt = 0;
    exp_t exp_q[$];

    ps2_dev_tx_if bus ();

    assign ps2_clk  = ~(clk_oe | host_clk_low);
    assign ps2_data = ~(data_oe | host_data_low);

    ps2_dev_tx #(.CLK_FREQ(CLK_FREQ), .HALF_TICKS(HALF_TICKS)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .tx            (bus),
        .ps2_clk_i     (ps2_clk),
        .ps2_data_i    (ps2_data),
        .ps2_clk_oe_o  (clk_oe),
        .ps2_data_oe_o (data_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // Monitor: decode bits, check CLK timing, pop the scoreboard on done/fail.
    initial begin : monitor
        logic        prev_oe;
        logic [10:0] bits;
        int          low_len, high_len;
        exp_t        e;
        prev_oe  = 1'b0;
        bits     = 11'd0;
        low_len  = 0;
        high_len = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_oe = 1'b0; bits = 11'd0; pulse_cnt = 0; low_len = 0; high_len = 0;
            end else begin
                if (clk_oe && !prev_oe) begin
                    if (pulse_cnt > 0) check("clk_high_width", high_len, HALF_CYC);
                    if (pulse_cnt < 11) bits[pulse_cnt] = ~data_oe;
                    pulse_cnt++;
                    low_len = 1;
                end else if (clk_oe) begin
                    low_len++;
                end else if (prev_oe) begin
                    check("clk_low_width", low_len, HALF_CYC);
                    high_len = 1;
                end else begin
                    high_len++;
                end
                prev_oe = clk_oe;
                if (bus.tx_done_o || bus.tx_fail_o) begin
                    check("done_fail_exclusive", int'(bus.tx_done_o & bus.tx_fail_o), 0);
                    check("oe_released_at_end", int'({clk_oe, data_oe}), 0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_pulse", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("outcome_is_fail", int'(bus.tx_fail_o), int'(e.is_fail));
                        if (bus.tx_done_o) begin
                            check("clk_pulse_count", pulse_cnt, 11);
                            check("frame_bits", int'(bits), int'(e.frame));
                        end
                    end
                    bits = 11'd0; pulse_cnt = 0;
                end
            end
        end
    end

    // Issue one request; optionally record its expected outcome.
    task automatic send(input logic [7:0] d, input logic push, input exp_t e);
        @(negedge clk);
        bus.tx_en_i   = 1'b1;
        bus.tx_data_i = d;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        bus.tx_en_i   = 1'b0;
    endtask

    task automatic wait_not_busy(input string name, input int max_cyc);
        int n = 0;
        while (bus.tx_busy_o && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (bus.tx_busy_o) check(name, 1, 0);
    endtask

    // Watchdog: the whole run is far shorter than this.
    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        int seen_clk;
        bus.tx_en_i   = 1'b0;
        bus.tx_data_i = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_clk_oe", int'(clk_oe), 0);
        check("reset_data_oe", int'(data_oe), 0);
        check("reset_busy", int'(bus.tx_busy_o), 0);
        check("reset_done", int'(bus.tx_done_o), 0);
        check("reset_fail", int'(bus.tx_fail_o), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_busy", int'(bus.tx_busy_o), 0);

        // Normal frames: 0x1C and parity corner bytes. Frame = {stop,par,data,start}.
        send(8'h1C, 1'b1, '{is_fail: 1'b0, frame: 11'h438});
        check("busy_after_request", int'(bus.tx_busy_o), 1);
        wait_not_busy("frame_1c_timeout", 3000);
        send(8'h00, 1'b1, '{is_fail: 1'b0, frame: 11'h600});
        wait_not_busy("frame_00_timeout", 3000);
        send(8'h01, 1'b1, '{is_fail: 1'b0, frame: 11'h402});
        wait_not_busy("frame_01_timeout", 3000);
        send(8'hFF, 1'b1, '{is_fail: 1'b0, frame: 11'h7FE});
        wait_not_busy("frame_ff_timeout", 3000);

        // Host holds DATA low: no CLK activity until 50 us idle + 20 us setup.
        repeat (20) @(negedge clk);
        host_data_low = 1'b1;
        send(8'h01, 1'b1, '{is_fail: 1'b0, frame: 11'h402});
        seen_clk = 0;
        repeat (30 * TICK_CYC) begin
            @(negedge clk);
            if (clk_oe) seen_clk = 1;
        end
        check("no_clk_while_data_low", seen_clk, 0);
        host_data_low = 1'b0;
        n = 0;
        while (!clk_oe && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_range("first_clk_low_delay", n, 14 * TICK_CYC, 16 * TICK_CYC);
        wait_not_busy("frame_held_timeout", 3000);

        // Host inhibits CLK during bit 5 high phase: abort.
        send(8'hA5, 1'b1, '{is_fail: 1'b1, frame: 11'h000});
        n = 0;
        while (!(pulse_cnt == 6 && !clk_oe) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("reach_bit5_high", int'(n < 3000), 1);
        @(negedge clk);
        host_clk_low = 1'b1;
        n = 0;
        while (!bus.tx_fail_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_range("fail_latency", n, 1, TICK_CYC + 3);
        @(negedge clk);
        check("busy_low_after_fail", int'(bus.tx_busy_o), 0);
        host_clk_low = 1'b0;
        repeat (20) @(negedge clk);

        // Second request while busy is dropped.
        send(8'h3C, 1'b1, '{is_fail: 1'b0, frame: 11'h678});
        repeat (500) @(negedge clk);
        send(8'hFF, 1'b0, '{is_fail: 1'b0, frame: 11'h000});
        wait_not_busy("frame_3c_timeout", 3000);
        repeat (300) @(negedge clk);
        check("no_queued_frame", int'(bus.tx_busy_o), 0);

        // Reset in the middle of a frame while DATA is pulled low.
        send(8'h00, 1'b0, '{is_fail: 1'b0, frame: 11'h000});
        n = 0;
        while (!(data_oe && pulse_cnt >= 3) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("data_oe_before_reset", int'(data_oe), 1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs",
              int'({clk_oe, data_oe, bus.tx_busy_o, bus.tx_done_o, bus.tx_fail_o}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        send(8'h55, 1'b1, '{is_fail: 1'b0, frame: 11'h6AA});
        wait_not_busy("frame_55_timeout", 3000);
        repeat (5) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
